// File: rtl/eth_frame_former_mc.sv
// Multi-channel Ethernet frame former: round-robin grant over NUM_CH payload
// streams, 20-byte header, zero pad to the minimum frame size, AXI4-Stream out.
module eth_frame_former_mc #(
  parameter int NUM_CH          = 2,
  parameter int DATA_BYTES      = 4,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int CNT_W           = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [47:0]                    Destination_Address,
  input  logic [47:0]                    Source_Address,
  input  logic [15:0]                    Link_Type,
  input  logic [15:0]                    SyncWord,
  input  logic [13:0]                    Packet_Size,
  input  logic [NUM_CH*DATA_BYTES*8-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]              s_axis_tvalid,
  input  logic [NUM_CH-1:0]              s_axis_tlast,
  output logic [NUM_CH-1:0]              s_axis_tready,
  output logic [DATA_BYTES*8-1:0]        m_axis_tdata,
  output logic [DATA_BYTES-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           busy,
  output logic [CNT_W-1:0]               frame_count,
  output logic                           err_short
);
  localparam int DW        = DATA_BYTES * 8;
  localparam int HB        = 20 / DATA_BYTES;
  localparam int MIN_BEATS = MIN_FRAME_BYTES / DATA_BYTES;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, PAD} state_t;

  state_t           state_q;
  logic [CH_W-1:0]  ptr_q, grant_q, grant_d;
  logic [CH_W:0]    grant_sum, ptr_next;
  logic [159:0]     hdr_q, hdr_d, hdr_be;
  logic [15:0]      beat_q, last_idx_q, pay_last_q;
  logic [15:0]      pay_end, frame_beats;
  logic             ps_zero_q, short_q, err_short_q;
  logic [CNT_W-1:0] frame_count_q;
  logic [NUM_CH-1:0] rot_valid;
  logic             found;
  logic [7:0]       ch_id;
  logic [DW-1:0]    sel_data, hdr_beat;
  logic             sel_valid, sel_last, hs;

  // Rotate valids so index 0 is the pointer; first set bit wins.
  always_comb begin
    rot_valid = NUM_CH'({s_axis_tvalid, s_axis_tvalid} >> ptr_q);
    grant_d   = ptr_q;
    grant_sum = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot_valid[i]) begin
        found     = 1'b1;
        grant_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
        if (grant_sum >= (CH_W+1)'(NUM_CH)) grant_sum = grant_sum - (CH_W+1)'(NUM_CH);
        grant_d   = grant_sum[CH_W-1:0];
      end
    end
    ptr_next = {1'b0, grant_d} + (CH_W+1)'(1);
    if (ptr_next >= (CH_W+1)'(NUM_CH)) ptr_next = '0;
  end

  assign ch_id  = 8'(grant_d);
  assign hdr_be = {Destination_Address, Source_Address, Link_Type, SyncWord,
                   ch_id, 8'h00, 2'b00, Packet_Size};

  // First header byte lands on the lowest lane.
  generate
    for (genvar gi = 0; gi < 20; gi++) begin : g_hdr_bytes
      assign hdr_d[8*gi +: 8] = hdr_be[159-8*gi -: 8];
    end
  endgenerate

  assign pay_end     = 16'(HB) + {2'b00, Packet_Size};
  assign frame_beats = (pay_end > 16'(MIN_BEATS)) ? pay_end : 16'(MIN_BEATS);

  assign sel_data  = DW'(s_axis_tdata >> (32'(grant_q) * DW));
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign hdr_beat  = DW'(hdr_q >> (32'(beat_q) * DW));

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      HDR: begin
        m_axis_tdata  = hdr_beat;
        m_axis_tvalid = 1'b1;
      end
      PAY: begin
        m_axis_tvalid = short_q | sel_valid;
        if (!short_q) m_axis_tdata = sel_data;
      end
      PAD:     m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == PAY && !short_q) s_axis_tready[grant_q] = m_axis_tready;
  end

  assign hs           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tkeep = {DATA_BYTES{m_axis_tvalid}};
  assign m_axis_tlast = m_axis_tvalid && (beat_q == last_idx_q);
  assign busy         = (state_q != IDLE);
  assign frame_count  = frame_count_q;
  assign err_short    = err_short_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      hdr_q         <= '0;
      beat_q        <= '0;
      last_idx_q    <= '0;
      pay_last_q    <= '0;
      ps_zero_q     <= 1'b0;
      short_q       <= 1'b0;
      err_short_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      err_short_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q    <= grant_d;
            ptr_q      <= ptr_next[CH_W-1:0];
            hdr_q      <= hdr_d;
            beat_q     <= '0;
            last_idx_q <= frame_beats - 16'd1;
            pay_last_q <= pay_end - 16'd1;
            ps_zero_q  <= (Packet_Size == 14'd0);
            short_q    <= 1'b0;
            state_q    <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            beat_q <= beat_q + 16'd1;
            if (beat_q == last_idx_q) begin
              frame_count_q <= frame_count_q + 1'b1;
              state_q       <= IDLE;
            end else if (beat_q == 16'(HB-1)) begin
              state_q <= ps_zero_q ? PAD : PAY;
            end
          end
        end
        PAY: begin
          if (hs) begin
            beat_q <= beat_q + 16'd1;
            // Producer ended early: stop accepting and zero-fill the rest.
            if (!short_q && sel_last && beat_q != pay_last_q) begin
              short_q     <= 1'b1;
              err_short_q <= 1'b1;
            end
            if (beat_q == last_idx_q) begin
              frame_count_q <= frame_count_q + 1'b1;
              state_q       <= IDLE;
            end else if (beat_q == pay_last_q) begin
              state_q <= PAD;
            end
          end
        end
        PAD: begin
          if (hs) begin
            beat_q <= beat_q + 16'd1;
            if (beat_q == last_idx_q) begin
              frame_count_q <= frame_count_q + 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_frame_former_mc.sv
// Directed bench for eth_frame_former_mc: header layout, padding, arbitration,
// backpressure, short payload and mid-frame reset.
module tb_eth_frame_former_mc;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [47:0] Destination_Address, Source_Address;
  logic [15:0] Link_Type, SyncWord;
  logic [13:0] Packet_Size;
  logic [63:0] s_axis_tdata;
  logic [1:0]  s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready, busy, err_short;
  logic [31:0] frame_count;

  always #5 ACLK = ~ACLK;

  eth_frame_former_mc #(.NUM_CH(2), .DATA_BYTES(4), .MIN_FRAME_BYTES(60), .CNT_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .Destination_Address(Destination_Address), .Source_Address(Source_Address),
    .Link_Type(Link_Type), .SyncWord(SyncWord), .Packet_Size(Packet_Size),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .frame_count(frame_count),
    .err_short(err_short)
  );

  int checks = 0, errors = 0;
  logic [32:0] q0[$], q1[$];
  logic [31:0] out_d[$], exp_d[$];
  logic        out_l[$], exp_l[$];
  int          out_cyc[$];
  int          cyc = 0, err_seen = 0, stall_viol = 0, keep_bad = 0, rdy_cnt = 0;
  bit          rdy_toggle = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic drive();
    s_axis_tvalid = 2'b00; s_axis_tlast = 2'b00; s_axis_tdata = '0;
    if (q0.size() != 0) begin
      s_axis_tvalid[0] = 1'b1; s_axis_tlast[0] = q0[0][32]; s_axis_tdata[31:0] = q0[0][31:0];
    end
    if (q1.size() != 0) begin
      s_axis_tvalid[1] = 1'b1; s_axis_tlast[1] = q1[0][32]; s_axis_tdata[63:32] = q1[0][31:0];
    end
    m_axis_tready = rdy_toggle ? ((rdy_cnt % 10) >= 7) : 1'b1;
    rdy_cnt++;
  endtask

  // One clock: observe at the falling edge, update sources just after the rising edge.
  task automatic cycle();
    bit hs0, hs1;
    @(negedge ACLK);
    cyc++;
    hs0 = s_axis_tvalid[0] && s_axis_tready[0];
    hs1 = s_axis_tvalid[1] && s_axis_tready[1];
    if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
      stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tkeep !== 4'hF) keep_bad++;
    if (m_axis_tvalid && m_axis_tready) begin
      out_d.push_back(m_axis_tdata); out_l.push_back(m_axis_tlast); out_cyc.push_back(cyc);
    end
    if (err_short === 1'b1) err_seen++;
    @(posedge ACLK); #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_frames(input int n, input int budget, input string name);
    int lasts, k;
    k = 0;
    while (k < budget) begin
      lasts = 0;
      foreach (out_l[i]) if (out_l[i]) lasts++;
      if (lasts >= n) break;
      cycle();
      k++;
    end
    if (k >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout frames_seen=%0d required=%0d", name, lasts, n);
    end
  endtask

  task automatic clear_io();
    out_d.delete(); out_l.delete(); out_cyc.delete(); exp_d.delete(); exp_l.delete();
    err_seen = 0; stall_viol = 0; keep_bad = 0; prev_stall = 1'b0;
  endtask

  // Queue source beats and append the hand-laid expected frame.
  task automatic load_frame(input int ch, input int ps, input int nreal, input int tag);
    logic [13:0] p;
    logic [31:0] d;
    p = 14'(ps);
    Packet_Size = p;
    exp_d.push_back(32'haf5c0bb0); exp_d.push_back(32'h0ff0afec);
    exp_d.push_back(32'h12feca00); exp_d.push_back(32'hadde3713);
    exp_d.push_back({p[7:0], 2'b00, p[13:8], 8'h00, 8'(ch)});
    for (int j = 0; j < ps; j++) begin
      d = 32'h5A000000 + 32'(ch * 1048576 + tag * 256 + j);
      if (j < nreal) begin
        if (ch == 0) q0.push_back({(j == nreal - 1), d});
        else         q1.push_back({(j == nreal - 1), d});
        exp_d.push_back(d);
      end else exp_d.push_back(32'h0);
    end
    for (int k = 5 + ps; k < 15; k++) exp_d.push_back(32'h0);
    while (exp_l.size() < exp_d.size()) exp_l.push_back(1'b0);
    exp_l[exp_l.size() - 1] = 1'b1;
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    q0.delete(); q1.delete(); rdy_toggle = 1'b0;
    drive();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    clear_io();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 4'h0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_keep_last got=%h/%b exp=0/0", m_axis_tkeep, m_axis_tlast); end
    checks++; if (busy !== 1'b0 || err_short !== 1'b0) begin errors++; $display("FAIL reset_busy_err got=%b/%b exp=0/0", busy, err_short); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    checks++; if (s_axis_tready !== 2'b00) begin errors++; $display("FAIL reset_sready got=%b exp=00", s_axis_tready); end
  endtask

  task automatic test_basic();
    clear_io();
    load_frame(0, 16, 16, 1);
    drive();
    run_frames(1, 200, "basic");
    checks++; if (out_d.size() != 21) begin errors++; $display("FAIL basic_len got=%0d exp=21", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    if (out_d.size() > 4) begin
      checks++; if (out_d[4] !== 32'h10000000) begin errors++; $display("FAIL basic_len_field got=%h exp=10000000", out_d[4]); end
    end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", frame_count); end
    checks++; if (keep_bad != 0) begin errors++; $display("FAIL basic_tkeep bad_beats=%0d exp=0", keep_bad); end
  endtask

  task automatic test_pad();
    clear_io();
    load_frame(0, 4, 4, 2);
    drive();
    run_frames(1, 200, "pad");
    checks++; if (out_d.size() != 15) begin errors++; $display("FAIL pad_len got=%0d exp=15", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL pad_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (frame_count !== 32'd2) begin errors++; $display("FAIL pad_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    load_frame(0, 2, 2, 0); load_frame(1, 2, 2, 0);
    load_frame(0, 2, 2, 1); load_frame(1, 2, 2, 1);
    drive();
    run_frames(4, 400, "b2b");
    checks++; if (out_d.size() != 60) begin errors++; $display("FAIL b2b_len got=%0d exp=60", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    for (int f = 0; f < 4; f++) if (15 * f + 4 < out_d.size()) begin
      checks++;
      if (out_d[15*f+4][7:0] !== 8'(f % 2)) begin
        errors++; $display("FAIL b2b_chid%0d got=%h exp=%h", f, out_d[15*f+4][7:0], 8'(f % 2));
      end
    end
    if (out_cyc.size() > 15) begin
      checks++;
      if (out_cyc[15] - out_cyc[14] != 2) begin
        errors++; $display("FAIL b2b_gap got=%0d exp=2", out_cyc[15] - out_cyc[14]);
      end
    end
    checks++; if (frame_count !== 32'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", frame_count); end
  endtask

  task automatic test_backpressure();
    clear_io();
    rdy_toggle = 1'b1; rdy_cnt = 0;
    load_frame(0, 16, 16, 3);
    drive();
    repeat (3) cycle();
    Destination_Address = 48'h0; Source_Address = 48'h0; Link_Type = 16'h0;
    run_frames(1, 600, "bp");
    Destination_Address = 48'hb00b5cafecaf; Source_Address = 48'hf00f00cafe12; Link_Type = 16'h1337;
    rdy_toggle = 1'b0;
    checks++; if (out_d.size() != 21) begin errors++; $display("FAIL bp_len got=%0d exp=21", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable changes=%0d exp=0", stall_viol); end
    checks++; if (frame_count !== 32'd5) begin errors++; $display("FAIL bp_count got=%0d exp=5", frame_count); end
  endtask

  task automatic test_short();
    clear_io();
    load_frame(0, 8, 3, 4);
    drive();
    run_frames(1, 200, "short");
    repeat (2) cycle();
    checks++; if (out_d.size() != 15) begin errors++; $display("FAIL short_len got=%0d exp=15", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL short_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (err_seen != 1) begin errors++; $display("FAIL short_err_pulses got=%0d exp=1", err_seen); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL short_src_left got=%0d exp=0", q0.size()); end
    checks++; if (frame_count !== 32'd6) begin errors++; $display("FAIL short_count got=%0d exp=6", frame_count); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_io();
    load_frame(0, 16, 16, 5);
    drive();
    k = 0;
    while (out_d.size() < 2 && k < 50) begin cycle(); k++; end
    checks++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", m_axis_tvalid, busy); end
    ARESETN = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b/%b exp=0/0", m_axis_tvalid, m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_data got=%h/%b exp=0/0", m_axis_tdata, busy); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", frame_count); end
    q0.delete();
    clear_io();
    load_frame(0, 16, 16, 5);
    drive();
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    drive();
    run_frames(1, 200, "rstmid");
    checks++; if (out_d.size() != 21) begin errors++; $display("FAIL rstmid_len got=%0d exp=21", out_d.size()); end
    foreach (exp_d[i]) if (i < out_d.size()) begin
      checks++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL rstmid_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL rstmid_count_after got=%0d exp=1", frame_count); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    Destination_Address = 48'hb00b5cafecaf;
    Source_Address      = 48'hf00f00cafe12;
    Link_Type           = 16'h1337;
    SyncWord            = 16'hdead;
    Packet_Size         = 14'd16;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_pad();
    test_back_to_back();
    test_backpressure();
    test_short();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
